// File: rtl/pasta_pkg.sv
// Shared byte-packing constants and the byte-lane mapping helper.
package pasta_pkg;

  localparam int WORD_W = 64;
  localparam int NBYTES = 8;
  localparam int IDX_W  = 3;

  // Lane that receives the byte at position idx; reverse puts byte 0 in the top lane.
  function automatic logic [IDX_W-1:0] lane_of(input logic [IDX_W-1:0] idx,
                                               input logic reverse);
    return reverse ? (3'd7 - idx) : idx;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 64-bit words with a single registered output slot.
// Optional BYTE_WORD_PACKER_PARTIAL_FLUSH_EN lets in_last close a short word.
module byte_word_packer
  import pasta_pkg::*;
#(
  parameter bit REVERSE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  output logic [3:0]        out_bytes,
  input  logic              out_ready
);

  // Handshakes: a byte moves when in_valid && in_ready at a rising edge; a word
  // moves when out_valid && out_ready. out_word/out_bytes hold while stalled.

  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_asm;
  logic [WORD_W-1:0] r_out_word;
  logic              r_out_valid;
  logic [3:0]        r_out_bytes;

  logic [IDX_W-1:0]  w_lane;
  logic [WORD_W-1:0] w_assembled;
  logic              w_completing;
  logic [3:0]        w_fill;
  logic              w_accept;
  logic              w_out_xfer;

  assign w_lane      = lane_of(r_idx, REVERSE);
  assign w_assembled = r_asm | (WORD_W'(in_byte) << {w_lane, 3'b000});

`ifdef BYTE_WORD_PACKER_PARTIAL_FLUSH_EN
  assign w_completing = (r_idx == 3'd7) || in_last;
  assign w_fill       = {1'b0, r_idx} + 4'd1;
`else
  logic w_unused_last;
  assign w_unused_last = in_last;
  assign w_completing  = (r_idx == 3'd7);
  assign w_fill        = 4'd8;
`endif

  // Only a completing byte needs the output slot to be free (or draining).
  assign in_ready   = !w_completing || !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_asm       <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
      r_out_bytes <= '0;
    end else begin
      if (w_accept && w_completing) begin
        r_out_word  <= w_assembled;
        r_out_bytes <= w_fill;
        r_out_valid <= 1'b1;
        r_idx       <= '0;
        r_asm       <= '0;
      end else begin
        if (w_accept) begin
          r_asm <= w_assembled;
          r_idx <= r_idx + 3'd1;
        end
        if (w_out_xfer) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_word  = r_out_word;
  assign out_valid = r_out_valid;
  assign out_bytes = r_out_bytes;

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: REVERSE=1 and REVERSE=0 instances share stimulus.
// Define BYTE_WORD_PACKER_PARTIAL_FLUSH_EN to exercise in_last flushing.
module tb_byte_word_packer;

`ifdef BYTE_WORD_PACKER_PARTIAL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        rev_in_ready, fwd_in_ready;
  logic [63:0] rev_word, fwd_word;
  logic        rev_valid, fwd_valid;
  logic [3:0]  rev_bytes, fwd_bytes;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cyc = 0;
  bit lat_due  = 0;
  int stalls   = 0;
  int n_out    = 0;

  logic [7:0]  msg[$];
  logic [67:0] exp_rev_q[$];
  logic [67:0] exp_fwd_q[$];
  logic [63:0] last_rev_word, last_fwd_word;
  logic [3:0]  last_rev_bytes;

  byte_word_packer #(.REVERSE(1'b1)) u_rev (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rev_in_ready), .out_word(rev_word), .out_valid(rev_valid),
    .out_bytes(rev_bytes), .out_ready(out_ready)
  );

  byte_word_packer #(.REVERSE(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(fwd_in_ready), .out_word(fwd_word), .out_valid(fwd_valid),
    .out_bytes(fwd_bytes), .out_ready(out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    chk("rst_rev_valid", {63'b0, rev_valid}, 64'd0);
    chk("rst_fwd_valid", {63'b0, fwd_valid}, 64'd0);
    chk("rst_rev_word", rev_word, 64'd0);
    chk("rst_fwd_word", fwd_word, 64'd0);
    chk("rst_rev_bytes", {60'b0, rev_bytes}, 64'd0);
    chk("rst_fwd_bytes", {60'b0, fwd_bytes}, 64'd0);
    chk("rst_in_ready", {63'b0, rev_in_ready & fwd_in_ready}, 64'd1);
    msg.delete();
    exp_rev_q.delete();
    exp_fwd_q.delete();
    lat_due = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'b0, rev_in_ready & fwd_in_ready}, 64'd1);
  endtask

  // ---------------- reference model ----------------
  task automatic model_accept(input logic [7:0] b, input bit last);
    logic [63:0] wr;
    logic [63:0] wf;
    int n;
    msg.push_back(b);
    if (msg.size() == 8 || (FLUSH && last)) begin
      n  = msg.size();
      wr = '0;
      wf = '0;
      for (int k = 0; k < n; k++) begin
        wr = (wr << 8) | 64'(msg[k]);
        wf = wf | (64'(msg[k]) << (8 * k));
      end
      wr = wr << (8 * (8 - n));
      exp_rev_q.push_back({4'(n), wr});
      exp_fwd_q.push_back({4'(n), wf});
      msg.delete();
      done_cyc = cyc;
      lat_due  = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input bit last, input bit rnd, input int release_after);
    int tries = 0;
    bit acc = 0;
    bit completing;
    bit exp_rdy;
    while (!acc) begin
      in_byte  = b;
      in_valid = 1'b1;
      in_last  = last;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (tries >= release_after) out_ready = 1'b1;
      #1;
      completing = (msg.size() == 7) || (FLUSH && last);
      exp_rdy    = !completing || (exp_rev_q.size() == 0) || out_ready;
      chk("in_ready_rev", {63'b0, rev_in_ready}, {63'b0, exp_rdy});
      chk("in_ready_fwd", {63'b0, fwd_in_ready}, {63'b0, exp_rdy});
      acc = rev_in_ready;
      if (acc) model_accept(b, last);
      else stalls++;
      @(negedge clk);
      tries++;
      if (!acc && tries > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: byte %h not accepted in 200 cycles", b);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_byte = 8'($urandom);
      in_last = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_rev_q.size() != 0 || exp_fwd_q.size() != 0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", 64'(exp_rev_q.size() + exp_fwd_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic mon_port(input bit rev, input logic v, input logic [63:0] w, input logic [3:0] n);
    logic [67:0] e;
    bit have;
    string tag;
    tag = rev ? "rev" : "fwd";
    if (!v) return;
    have = rev ? (exp_rev_q.size() > 0) : (exp_fwd_q.size() > 0);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s_spurious: out_valid=1 word=%h got no expected word queued", tag, w);
      return;
    end
    e = rev ? exp_rev_q[0] : exp_fwd_q[0];
    chk($sformatf("%s_word", tag), w, e[63:0]);
    chk($sformatf("%s_bytes", tag), {60'b0, n}, {60'b0, e[67:64]});
    if (out_ready) begin
      if (rev) begin
        void'(exp_rev_q.pop_front());
        last_rev_word  = w;
        last_rev_bytes = n;
        n_out++;
      end else begin
        void'(exp_fwd_q.pop_front());
        last_fwd_word = w;
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (lat_due && cyc == done_cyc + 1) begin
        chk("latency_valid", {63'b0, rev_valid & fwd_valid}, 64'd1);
        lat_due = 1'b0;
      end
      mon_port(1'b1, rev_valid, rev_word, rev_bytes);
      mon_port(1'b0, fwd_valid, fwd_word, fwd_bytes);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst       = 1'b1;
    in_byte   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // bytes 01..08 back to back
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b0, 1000);
    drain();
    chk("dir_rev_word", last_rev_word, 64'h0102030405060708);
    chk("dir_fwd_word", last_fwd_word, 64'h0807060504030201);
    chk("dir_rev_bytes", {60'b0, last_rev_bytes}, 64'd8);

    // output stalled across two words
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0, 1'b0, (i == 16) ? 3 : 1000);
    drain();
    chk("stall_rev_word2", last_rev_word, 64'h090A0B0C0D0E0F10);
    chk("stall_fwd_word2", last_fwd_word, 64'h100F0E0D0C0B0A09);

    if (FLUSH) begin
      send_byte(8'hAA, 1'b0, 1'b0, 1000);
      send_byte(8'hBB, 1'b0, 1'b0, 1000);
      send_byte(8'hCC, 1'b1, 1'b0, 1000);
      drain();
      chk("flush_rev_word", last_rev_word, 64'hAABBCC0000000000);
      chk("flush_rev_bytes", {60'b0, last_rev_bytes}, 64'd3);
      for (int i = 1; i <= 8; i++) send_byte(8'(8'h20 + i), 1'b0, 1'b0, 1000);
      drain();
      chk("flush_next_word", last_rev_word, 64'h2122232425262728);
    end

    // reset with a partial word in flight
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1000);
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 + i), 1'b0, 1'b0, 1000);
    drain();
    chk("rst_partial_word", last_rev_word, 64'h1112131415161718);

    // streaming 64 random bytes
    stalls = 0;
    base   = n_out;
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0, 1'b0, 1000);
    drain();
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_words", 64'(n_out - base), 64'd8);

    // random traffic with backpressure and gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_byte(8'($urandom), FLUSH ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1)),
                1'b1, 1000);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
